// File: rtl/pipe_buf_stage_pkg.sv
// Shared types for the pipeline buffer stage: FSM encodings, occupancy type,
// and the flush drop-amount helper.
package pipe_buf_stage_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] occ_t;

  // The encoding equals the number of held entries.
  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_TWO   = 2'd2;

  // Entries a flush discards: everything held, minus the one leaving this cycle.
  function automatic occ_t drop_amount(input occ_t occ, input logic emit);
    return occ - {1'b0, emit};
  endfunction

endpackage

// File: rtl/pipe_buf_stage_if.sv
// Valid/ready payload channel. The master drives valid and data; the slave
// drives ready.
interface pipe_buf_stage_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_buf_entry.sv
// One payload register with a valid bit. Load takes priority over clear.
// Clear drops only the valid bit, so the data stays on the bus.
module pipe_buf_entry #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      data_q <= RESET_VAL;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_buf_stage.sv
// Reusable pipeline register stage with valid/ready, flush and an optional
// skid entry. It has 1-cycle latency and keeps a saturating count of entries killed by flush.
module pipe_buf_stage
  import pipe_buf_stage_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter bit                SKID_EN   = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  pipe_buf_stage_if.slave  in_if,
  pipe_buf_stage_if.master out_if,
  input  logic             flush,
  output occ_t             occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t            state_q, state_d;
  logic              in_rdy, accept, emit;
  logic              m_load, m_clr, s_load, s_clr;
  logic              m_vld, s_vld;
  logic [DATA_W-1:0] m_din, m_dat, s_dat;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W:0]    drop_sum;

  // The skid variant registers ready, which cuts the out_ready -> in_ready path.
  always_comb begin
    if (SKID_EN) in_rdy = (state_q != ST_TWO) & ~flush & reset_n;
    else         in_rdy = (~m_vld | out_if.ready) & ~flush & reset_n;
  end

  assign accept = in_if.valid & in_rdy;
  assign emit   = m_vld & out_if.ready;

  always_comb begin
    state_d = state_q;
    m_load  = 1'b0;
    m_clr   = 1'b0;
    s_load  = 1'b0;
    s_clr   = 1'b0;
    m_din   = in_if.data;
    if (flush) begin
      state_d = ST_EMPTY;
      m_clr   = 1'b1;
      s_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_ONE;
          m_load  = 1'b1;
        end
        ST_ONE: begin
          if (accept && emit) begin
            m_load = 1'b1;
          end else if (accept && SKID_EN) begin
            state_d = ST_TWO;
            s_load  = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
            m_clr   = 1'b1;
          end
        end
        ST_TWO: if (emit) begin
          state_d = ST_ONE;
          m_load  = 1'b1;
          m_din   = s_dat;
          s_clr   = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_amount(occupancy, emit));
    drop_d   = drop_q;
    if (flush) drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  pipe_buf_entry #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (m_load),
    .clr_i   (m_clr),
    .data_i  (m_din),
    .vld_o   (m_vld),
    .data_o  (m_dat)
  );

  if (SKID_EN) begin : g_skid
    pipe_buf_entry #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (s_load),
      .clr_i   (s_clr),
      .data_i  (in_if.data),
      .vld_o   (s_vld),
      .data_o  (s_dat)
    );
  end else begin : g_noskid
    assign s_vld = s_load & s_clr;
    assign s_dat = RESET_VAL;
  end

  assign in_if.ready  = in_rdy;
  assign out_if.valid = m_vld;
  assign out_if.data  = m_dat;
  assign occupancy    = occ_t'(m_vld) + occ_t'(s_vld);
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Bench for pipe_buf_stage. It drives a skid instance (CNT_W=2) from a vector table with a scoreboard,
// and drives a pass-through instance from a hand-written sequence.
module tb_pipe_buf_stage;
  import pipe_buf_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, b_rst_n, a_flush, b_flush;
  occ_t       a_occ, b_occ;
  logic [1:0] a_drop;
  logic [7:0] b_drop;

  pipe_buf_stage_if #(.DATA_W(32)) a_in ();
  pipe_buf_stage_if #(.DATA_W(32)) a_out ();
  pipe_buf_stage_if #(.DATA_W(32)) b_in ();
  pipe_buf_stage_if #(.DATA_W(32)) b_out ();

  pipe_buf_stage #(.DATA_W(32), .SKID_EN(1'b1), .RESET_VAL(32'h0), .CNT_W(2)) u_a (
    .clk(clk), .reset_n(a_rst_n), .in_if(a_in), .out_if(a_out),
    .flush(a_flush), .occupancy(a_occ), .drop_cnt(a_drop)
  );

  pipe_buf_stage #(.DATA_W(32), .SKID_EN(1'b0), .RESET_VAL(32'hDEAD_BEEF), .CNT_W(8)) u_b (
    .clk(clk), .reset_n(b_rst_n), .in_if(b_in), .out_if(b_out),
    .flush(b_flush), .occupancy(b_occ), .drop_cnt(b_drop)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, req);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        fl;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    int          e_occ;
    int          e_drop;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic rdy,
                              input logic fl, input logic e_rdy, input logic e_vld,
                              input logic [31:0] e_dat, input int e_occ, input int e_drop);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.fl = fl; t.e_rdy = e_rdy;
    t.e_vld = e_vld; t.e_dat = e_dat; t.e_occ = e_occ; t.e_drop = e_drop;
    return t;
  endfunction

  logic [31:0] sbq[$];
  int          drop_m = 0;
  vec_t        tbl[$];

  task automatic step_a(input vec_t t, input string tag);
    logic        acc, em, hold;
    logic [31:0] prev, exp_d;
    int          nd;
    @(negedge clk);
    a_in.valid = t.v; a_in.data = t.d; a_out.ready = t.rdy; a_flush = t.fl;
    #1;
    chk({tag, "_in_ready"}, 32'(a_in.ready), 32'(t.e_rdy));
    acc  = t.v & a_in.ready;
    em   = a_out.valid & t.rdy;
    hold = a_out.valid & ~t.rdy;
    prev = a_out.data;
    if (em) begin
      chk({tag, "_sb_nonempty"}, 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp_d = sbq.pop_front();
        chk({tag, "_sb_data"}, a_out.data, exp_d);
      end
    end
    if (acc) sbq.push_back(t.d);
    if (t.fl) begin
      nd     = drop_m + sbq.size();
      drop_m = (nd > 3) ? 3 : nd;
      sbq.delete();
    end
    @(posedge clk);
    #1;
    chk({tag, "_occ"}, 32'(a_occ), 32'(t.e_occ));
    chk({tag, "_occ_model"}, 32'(a_occ), 32'(sbq.size()));
    chk({tag, "_out_valid"}, 32'(a_out.valid), 32'(t.e_vld));
    chk({tag, "_out_data"}, a_out.data, t.e_dat);
    chk({tag, "_drop"}, 32'(a_drop), 32'(t.e_drop));
    chk({tag, "_drop_model"}, 32'(a_drop), 32'(drop_m));
    if (hold) chk({tag, "_hold"}, a_out.data, prev);
    if (sbq.size() != 0) chk({tag, "_sb_head"}, a_out.data, sbq[0]);
  endtask

  task automatic reset_a(input string tag);
    @(negedge clk);
    a_rst_n = 1'b0; a_in.valid = 1'b1; a_in.data = 32'h9A; a_out.ready = 1'b0; a_flush = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(a_in.ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_out_valid"}, 32'(a_out.valid), 32'd0);
    chk({tag, "_out_data"}, a_out.data, 32'h0);
    chk({tag, "_occ"}, 32'(a_occ), 32'd0);
    chk({tag, "_drop"}, 32'(a_drop), 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1; a_in.valid = 1'b0; a_flush = 1'b0;
    sbq.delete();
    drop_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
    a_in.valid = 1'b1; a_in.data = 32'h1234; a_out.ready = 1'b0;
    b_in.valid = 1'b1; b_in.data = 32'h1234; b_out.ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_a_in_ready", 32'(a_in.ready), 32'd0);
    chk("rst_b_in_ready", 32'(b_in.ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_a_out_valid", 32'(a_out.valid), 32'd0);
    chk("rst_a_out_data", a_out.data, 32'h0);
    chk("rst_a_occ", 32'(a_occ), 32'd0);
    chk("rst_a_drop", 32'(a_drop), 32'd0);
    chk("rst_b_out_valid", 32'(b_out.valid), 32'd0);
    chk("rst_b_out_data", b_out.data, 32'hDEAD_BEEF);
    chk("rst_b_drop", 32'(b_drop), 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1; a_in.valid = 1'b0; b_in.valid = 1'b0;

    //         v  d      rdy fl e_rdy vld dat    occ drop
    tbl.push_back(mk(1, 32'h1,  1, 0, 1, 1, 32'h1,  1, 0));  // streaming
    tbl.push_back(mk(1, 32'h2,  1, 0, 1, 1, 32'h2,  1, 0));
    tbl.push_back(mk(1, 32'h3,  1, 0, 1, 1, 32'h3,  1, 0));
    tbl.push_back(mk(0, 32'h0,  1, 0, 1, 0, 32'h3,  0, 0));
    tbl.push_back(mk(1, 32'hA,  0, 0, 1, 1, 32'hA,  1, 0));  // backpressure
    tbl.push_back(mk(1, 32'hB,  0, 0, 1, 1, 32'hA,  2, 0));
    tbl.push_back(mk(1, 32'hC,  0, 0, 0, 1, 32'hA,  2, 0));
    tbl.push_back(mk(0, 32'h0,  1, 0, 0, 1, 32'hB,  1, 0));
    tbl.push_back(mk(0, 32'h0,  1, 0, 1, 0, 32'hB,  0, 0));
    tbl.push_back(mk(1, 32'hD,  0, 0, 1, 1, 32'hD,  1, 0));  // flush two held
    tbl.push_back(mk(1, 32'hE,  0, 0, 1, 1, 32'hD,  2, 0));
    tbl.push_back(mk(1, 32'hF,  0, 1, 0, 0, 32'hD,  0, 2));
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 32'hD,  0, 2));  // flush while empty
    tbl.push_back(mk(1, 32'h10, 0, 0, 1, 1, 32'h10, 1, 2));  // flush with emit
    tbl.push_back(mk(0, 32'h0,  1, 1, 0, 0, 32'h10, 0, 2));
    tbl.push_back(mk(1, 32'h20, 0, 0, 1, 1, 32'h20, 1, 2));  // flush TWO with emit
    tbl.push_back(mk(1, 32'h21, 0, 0, 1, 1, 32'h20, 2, 2));
    tbl.push_back(mk(0, 32'h0,  1, 1, 0, 0, 32'h20, 0, 3));
    tbl.push_back(mk(1, 32'h30, 0, 0, 1, 1, 32'h30, 1, 3));  // already saturated
    tbl.push_back(mk(0, 32'h0,  0, 1, 0, 0, 32'h30, 0, 3));
    foreach (tbl[i]) step_a(tbl[i], $sformatf("vec%0d", i));

    reset_a("rst_a1");
    for (int i = 0; i < 4; i++) begin
      step_a(mk(1, 32'h40 + i, 0, 0, 1, 1, 32'h40 + i, 1, (i < 3) ? i : 3),
             $sformatf("sat_load%0d", i));
      step_a(mk(0, 32'h0, 0, 1, 0, 0, 32'h40 + i, 0, (i + 1 > 3) ? 3 : i + 1),
             $sformatf("sat_flush%0d", i));
    end
    step_a(mk(1, 32'h99, 0, 0, 1, 1, 32'h99, 1, 3), "pre_rst");
    reset_a("rst_a2");

    // Pass-through variant: ready follows out_ready combinationally.
    @(negedge clk);
    b_in.valid = 1'b1; b_in.data = 32'h55; b_out.ready = 1'b0;
    #1 chk("b_empty_ready", 32'(b_in.ready), 32'd1);
    @(posedge clk); #1;
    chk("b_load_valid", 32'(b_out.valid), 32'd1);
    chk("b_load_data", b_out.data, 32'h55);
    @(negedge clk);
    b_in.data = 32'h66;
    #1 chk("b_stall_ready", 32'(b_in.ready), 32'd0);
    b_out.ready = 1'b1;
    #1 chk("b_comb_ready", 32'(b_in.ready), 32'd1);
    chk("b_emit_data", b_out.data, 32'h55);
    @(posedge clk); #1;
    chk("b_swap_data", b_out.data, 32'h66);
    chk("b_swap_occ", 32'(b_occ), 32'd1);
    @(negedge clk);
    b_in.data = 32'h77;
    @(posedge clk); #1;
    chk("b_stream_data", b_out.data, 32'h77);
    chk("b_stream_occ", 32'(b_occ), 32'd1);
    @(negedge clk);
    b_in.valid = 1'b0; b_out.ready = 1'b0; b_flush = 1'b1;
    #1 chk("b_flush_ready", 32'(b_in.ready), 32'd0);
    @(posedge clk); #1;
    chk("b_flush_valid", 32'(b_out.valid), 32'd0);
    chk("b_flush_data", b_out.data, 32'h77);
    chk("b_flush_drop", 32'(b_drop), 32'd1);
    @(negedge clk);
    b_flush = 1'b0; b_in.valid = 1'b1; b_in.data = 32'h88;
    @(posedge clk); #1;
    chk("b_reload_data", b_out.data, 32'h88);
    @(negedge clk);
    b_rst_n = 1'b0; b_in.data = 32'h89; b_out.ready = 1'b1;
    #1 chk("b_rst_ready", 32'(b_in.ready), 32'd0);
    @(posedge clk); #1;
    chk("b_rst_valid", 32'(b_out.valid), 32'd0);
    chk("b_rst_data", b_out.data, 32'hDEAD_BEEF);
    chk("b_rst_occ", 32'(b_occ), 32'd0);
    chk("b_rst_drop", 32'(b_drop), 32'd0);
    @(negedge clk);
    b_rst_n = 1'b1; b_in.valid = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_buf_stage.md
Name: pipe_buf_stage

Overview:
- Generic, parametrised pipeline buffer register. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches of the RISC-V core with one reusable stage.
- Carries an opaque DATA_W-bit payload, normally a packed stage struct, using a valid/ready handshake, synchronous flush, an optional 2-entry skid buffer for full throughput under backpressure, and a saturating flush-drop counter.
- One instance sits between each pair of pipeline stages.

Parameters:
- DATA_W, 32: payload width; instantiated as the width of the packed stage struct.
- SKID_EN, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with pass-through ready.
- RESET_VAL, '0: out_data value after reset (DATA_W bits).
- CNT_W, 8: width of drop_cnt.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage holds valid payload (registered)
- out_ready  in  1  downstream accepts (low = stall)
- out_data  out  DATA_W  payload in main entry M (registered)
- flush  in  1  kill all held entries (hazard/branch squash)
- occupancy  out  2  entries held, 0..2
- drop_cnt  out  CNT_W  valid entries discarded by flush, saturating

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low on reset_n.
- Storage and handshake:
  - Two storage entries: main M (drives out_*) and skid S (SKID_EN=1 only).
  - accept = in_valid & in_ready; emit = out_valid & out_ready.
- Reset (reset_n=0 at a clk edge):
  - state EMPTY, out_valid=0, out_data=RESET_VAL, S cleared, occupancy=0, drop_cnt=0.
  - in_ready forced 0 while reset_n=0.
- States (SKID_EN=1): EMPTY (occ 0), ONE (M valid, occ 1), TWO (M and S valid, occ 2).
  - EMPTY: accept -> ONE, M<=in_data.
  - ONE: accept&emit -> ONE, M<=in_data. accept&!emit -> TWO, S<=in_data. emit only -> EMPTY. Neither -> hold.
  - TWO: emit -> ONE, M<=S. Otherwise hold. No accept possible.
  - in_ready = (state!=TWO) & !flush & reset_n. It depends only on registered state plus flush, with no combinational path from out_ready.
- SKID_EN=0:
  - States EMPTY/ONE only.
  - in_ready = (!out_valid | out_ready) & !flush & reset_n.
  - accept loads M. emit without accept -> EMPTY.
  - Zero-bubble throughput of 1 per cycle.
- Latency: accepted payload appears on out_data the next cycle (1 cycle) when the stage was empty or M was emitted that cycle.
- Ordering: strict FIFO; S never overtakes M.
- Hold: while out_ready=0, out_data and out_valid are stable.
- Flush:
  - Next state EMPTY; occupancy->0.
  - out_data keeps its last value; only valid bits clear.
  - in_ready=0 during flush, so no accept can coincide with flush.
  - An emit in the flush cycle still completes; downstream owns that transfer.
  - drop_cnt += entries held and not emitted that cycle (0, 1 or 2), saturating at 2^CNT_W-1.
- Simultaneous events: reset_n=0 overrides flush, which overrides the handshake.
- Flush while EMPTY: no effect, drop_cnt unchanged.
- Reset mid-transfer: payload lost, no drop counted.
- Assertions (bench): in_data stable not required; out_valid & !out_ready holds out_data the next cycle; occupancy never 3; state TWO unreachable with SKID_EN=0.

Decomposition:
- Package pipe_buf_stage_pkg: state enum (EMPTY, ONE, TWO) and occupancy typedef.
- Existing stage struct package: supplies the DATA_W payloads via $bits of each struct.
- Sub-module pipe_buf_entry: one data register plus valid bit with load/clear enables and RESET_VAL. Instantiated for M, and for S when SKID_EN=1.

Test Plan:
- Streaming, SKID_EN=1, DATA_W=32: in_valid=1, data 0x1,0x2,0x3 on consecutive cycles, out_ready=1 -> out_data 0x1,0x2,0x3 one cycle later, in_ready=1 throughout, occupancy=1.
- Backpressure: send 0xA,0xB, out_ready=0 -> occupancy 2, in_ready=0, out_data holds 0xA. Raise out_ready -> 0xA then 0xB, no loss or duplication.
- Flush with 2 held: state TWO, flush=1 with out_ready=0 -> next cycle out_valid=0, occupancy=0, drop_cnt=2, in_ready=0 in the flush cycle.
- Flush with emit: state ONE, out_ready=1, flush=1 -> transfer completes, drop_cnt unchanged, stage EMPTY.
- Saturation, CNT_W=2: four flushes of one entry each -> drop_cnt 1,2,3,3.
- SKID_EN=0 plus reset mid-operation: stalled holding 0x55, in_valid=1 with out_ready=0 -> in_ready=0. Then out_ready=1 -> in_ready=1 combinationally, 0x55 emitted, new data loaded the same cycle. reset_n=0 mid-stream -> out_valid=0, out_data=RESET_VAL, drop_cnt=0.
